// File: rtl/rotor_step_driver_pkg.sv
// ============================================================================
//  Module      : rotor_step_driver_pkg
//  Description : Shared rotor constants, notch defaults and driver encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rotor_step_driver_pkg;

    localparam int         ROTOR_SIZE = 26;
    localparam logic [6:0] ROTOR_MAX  = 7'd25;

    // Default turnover notch positions (Q, E, V)
    localparam int NOTCH_Q = 16;
    localparam int NOTCH_E = 4;
    localparam int NOTCH_V = 21;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } drv_state_t;

    typedef enum logic {
        MODE_STEP = 1'b0,
        MODE_LOAD = 1'b1
    } drv_mode_t;

    // Positions beyond the rotor range never sit on a notch.
    function automatic logic at_notch(input logic [6:0] pos, input int notch);
        return (pos <= ROTOR_MAX) && (pos == 7'(notch));
    endfunction

endpackage

`default_nettype wire

// File: rtl/rotor_step_driver_if.sv
// ============================================================================
//  Module      : rotor_step_driver_if
//  Description : Keypress handshake, rotor positions and rotor pulse lines.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rotor_step_driver_if;

    logic       key_valid;
    logic       key_ready;
    logic       load_req;
    logic [6:0] pos_r;
    logic [6:0] pos_m;
    logic [6:0] pos_l;
    logic       inc_r;
    logic       inc_m;
    logic       inc_l;
    logic       load_out;
    logic       busy;
    logic       step_done;

    modport master (
        input  key_valid, load_req, pos_r, pos_m, pos_l,
        output key_ready, inc_r, inc_m, inc_l, load_out, busy, step_done
    );

    modport slave (
        output key_valid, load_req, pos_r, pos_m, pos_l,
        input  key_ready, inc_r, inc_m, inc_l, load_out, busy, step_done
    );

endinterface

`default_nettype wire

// File: rtl/rotor_step_driver_turnover_decode.sv
// ============================================================================
//  Module      : rotor_turnover_decode
//  Description : Combinational stepping decision from right/middle positions.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rotor_turnover_decode
    import rotor_step_driver_pkg::*;
#(
    parameter int NOTCH_R = NOTCH_Q,
    parameter int NOTCH_M = NOTCH_E
) (
    input  logic [6:0] pos_r_i,
    input  logic [6:0] pos_m_i,
    output logic       step_r_o,
    output logic       step_m_o,
    output logic       step_l_o
);

    logic w_r_notch;
    logic w_m_notch;

    assign w_r_notch = at_notch(pos_r_i, NOTCH_R);
    assign w_m_notch = at_notch(pos_m_i, NOTCH_M);

    // Middle at its notch steps itself again: the double-step.
    assign step_r_o = 1'b1;
    assign step_m_o = w_r_notch | w_m_notch;
    assign step_l_o = w_m_notch;

endmodule

`default_nettype wire

// File: rtl/rotor_step_driver.sv
// ============================================================================
//  Module      : rotor_step_driver
//  Description : Keypress-driven rotor stepper emitting registered inc/load pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rotor_step_driver
    import rotor_step_driver_pkg::*;
#(
    parameter int NOTCH_R      = NOTCH_Q,
    parameter int NOTCH_M      = NOTCH_E,
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    rotor_step_driver_if.master   bus
);

    localparam logic [3:0] PULSE_LOAD = 4'(PULSE_CYCLES - 1);
    localparam logic [3:0] GAP_LOAD   = 4'(GAP_CYCLES - 1);

    drv_state_t state_q, state_d;
    drv_mode_t  mode_q,  mode_d;
    logic [3:0] cnt_q,   cnt_d;
    logic [2:0] mask_q,  mask_d;

    logic [2:0] inc_q;
    logic       load_q;
    logic       done_q;
    logic       ready_q;
    logic       busy_q;

    logic       w_step_r;
    logic       w_step_m;
    logic       w_step_l;
    logic       w_unused;

    // Left position has no notch effect; kept on the interface for the path checker.
    assign w_unused = &{1'b0, bus.pos_l};

    rotor_turnover_decode #(
        .NOTCH_R (NOTCH_R),
        .NOTCH_M (NOTCH_M)
    ) u_decode (
        .pos_r_i  (bus.pos_r),
        .pos_m_i  (bus.pos_m),
        .step_r_o (w_step_r),
        .step_m_o (w_step_m),
        .step_l_o (w_step_l)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.load_req) begin
                    state_d = ST_PULSE;
                    mode_d  = MODE_LOAD;
                    cnt_d   = PULSE_LOAD;
                end else if (bus.key_valid) begin
                    state_d = ST_PULSE;
                    mode_d  = MODE_STEP;
                    cnt_d   = PULSE_LOAD;
                    mask_d  = {w_step_l, w_step_m, w_step_r};
                end
            end
            ST_PULSE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they toggle on the same edge as the state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_STEP;
            cnt_q   <= 4'd0;
            mask_q  <= 3'b000;
            inc_q   <= 3'b000;
            load_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            inc_q   <= (state_d == ST_PULSE && mode_d == MODE_STEP) ? mask_d : 3'b000;
            load_q  <= (state_d == ST_PULSE && mode_d == MODE_LOAD);
            done_q  <= (state_d == ST_DONE);
            ready_q <= (state_d == ST_IDLE);
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign bus.inc_r     = inc_q[0];
    assign bus.inc_m     = inc_q[1];
    assign bus.inc_l     = inc_q[2];
    assign bus.load_out  = load_q;
    assign bus.step_done = done_q;
    assign bus.key_ready = ready_q;
    assign bus.busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_rotor_step_driver.sv
// ============================================================================
//  Module      : tb_rotor_step_driver
//  Description : Directed self-checking bench for rotor_step_driver.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rotor_step_driver;

    logic clk;
    logic resetn;
    int   checks;
    int   failures;

    rotor_step_driver_if bus ();

    rotor_step_driver #(
        .NOTCH_R      (16),
        .NOTCH_M      (4),
        .PULSE_CYCLES (2),
        .GAP_CYCLES   (2)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int n = 0; n < 20 && !bus.key_ready; n++) tick();
        checks++;
        if (bus.key_ready !== 1'b1) begin
            failures++;
            $display("FAIL wait_ready: key_ready=%b required 1 within 20 cycles", bus.key_ready);
        end
    endtask

    task automatic test_reset();
        resetn        = 1'b0;
        bus.key_valid = 1'b1;
        bus.load_req  = 1'b0;
        bus.pos_r     = 7'd0;
        bus.pos_m     = 7'd0;
        bus.pos_l     = 7'd0;
        #1;
        tick();
        tick();
        checks++;
        if ({bus.inc_l, bus.inc_m, bus.inc_r, bus.load_out} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_pulses: got %b required 0000",
                     {bus.inc_l, bus.inc_m, bus.inc_r, bus.load_out});
        end
        checks++;
        if (bus.key_ready !== 1'b1 || bus.busy !== 1'b0 || bus.step_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_status: ready/busy/done=%b%b%b required 100",
                     bus.key_ready, bus.busy, bus.step_done);
        end
        bus.key_valid = 1'b0;
        resetn        = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            checks++;
            if ({bus.inc_l, bus.inc_m, bus.inc_r, bus.load_out, bus.key_ready} !== 5'b00001) begin
                failures++;
                $display("FAIL reset_release_idle: got %b required 00001",
                         {bus.inc_l, bus.inc_m, bus.inc_r, bus.load_out, bus.key_ready});
            end
        end
    endtask

    // Each row: pos_r, pos_m, expected {inc_l,inc_m,inc_r}
    task automatic test_step_vectors();
        logic [6:0] vr [6];
        logic [6:0] vm [6];
        logic [2:0] vmask [6];
        logic [2:0] exp_inc;
        vr[0] = 7'd0;  vm[0] = 7'd0;  vmask[0] = 3'b001; // plain step
        vr[1] = 7'd16; vm[1] = 7'd0;  vmask[1] = 3'b011; // right turnover
        vr[2] = 7'd17; vm[2] = 7'd4;  vmask[2] = 3'b111; // double-step
        vr[3] = 7'd30; vm[3] = 7'd30; vmask[3] = 3'b001; // out of range
        vr[4] = 7'd16; vm[4] = 7'd4;  vmask[4] = 3'b111; // both notches
        vr[5] = 7'd15; vm[5] = 7'd26; vmask[5] = 3'b001; // just off notch / range
        for (int i = 0; i < 6; i++) begin
            wait_ready();
            bus.pos_r     = vr[i];
            bus.pos_m     = vm[i];
            bus.pos_l     = 7'd3;
            bus.key_valid = 1'b1;
            tick();
            // Positions move after the accept; the snapshot must not follow them.
            bus.key_valid = 1'b0;
            bus.load_req  = 1'b1;
            bus.pos_r     = 7'd16;
            bus.pos_m     = 7'd4;
            for (int j = 0; j < 6; j++) begin
                if (j > 0) tick();
                exp_inc = (j < 2) ? vmask[i] : 3'b000;
                checks++;
                if ({bus.inc_l, bus.inc_m, bus.inc_r} !== exp_inc) begin
                    failures++;
                    $display("FAIL step_inc v%0d c%0d: got %b required %b",
                             i, j, {bus.inc_l, bus.inc_m, bus.inc_r}, exp_inc);
                end
                checks++;
                if (bus.load_out !== 1'b0) begin
                    failures++;
                    $display("FAIL step_load v%0d c%0d: got %b required 0", i, j, bus.load_out);
                end
                checks++;
                if (bus.step_done !== (j == 4)) begin
                    failures++;
                    $display("FAIL step_done v%0d c%0d: got %b required %b",
                             i, j, bus.step_done, (j == 4));
                end
                checks++;
                if (bus.key_ready !== (j == 5) || bus.busy !== (j != 5)) begin
                    failures++;
                    $display("FAIL step_ready v%0d c%0d: ready/busy=%b%b required %b%b",
                             i, j, bus.key_ready, bus.busy, (j == 5), (j != 5));
                end
                if (j == 4) bus.load_req = 1'b0;
            end
        end
    endtask

    task automatic test_priority();
        logic exp_load;
        wait_ready();
        bus.pos_r     = 7'd0;
        bus.pos_m     = 7'd0;
        bus.key_valid = 1'b1;
        bus.load_req  = 1'b1;
        #1;
        checks++;
        if (bus.key_ready !== 1'b1) begin
            failures++;
            $display("FAIL prio_ready: got %b required 1", bus.key_ready);
        end
        tick();
        bus.load_req = 1'b0;
        for (int j = 0; j < 7; j++) begin
            if (j > 0) tick();
            exp_load = (j < 2);
            checks++;
            if (bus.load_out !== exp_load) begin
                failures++;
                $display("FAIL prio_load c%0d: got %b required %b", j, bus.load_out, exp_load);
            end
            checks++;
            if ({bus.inc_l, bus.inc_m, bus.inc_r} !== ((j == 6) ? 3'b001 : 3'b000)) begin
                failures++;
                $display("FAIL prio_inc c%0d: got %b required %b", j,
                         {bus.inc_l, bus.inc_m, bus.inc_r}, ((j == 6) ? 3'b001 : 3'b000));
            end
            checks++;
            if (bus.step_done !== (j == 4)) begin
                failures++;
                $display("FAIL prio_done c%0d: got %b required %b", j, bus.step_done, (j == 4));
            end
        end
        bus.key_valid = 1'b0;
        wait_ready();
    endtask

    task automatic test_abort();
        wait_ready();
        bus.pos_r     = 7'd16;
        bus.pos_m     = 7'd4;
        bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        checks++;
        if ({bus.inc_l, bus.inc_m, bus.inc_r} !== 3'b111) begin
            failures++;
            $display("FAIL abort_pre: got %b required 111", {bus.inc_l, bus.inc_m, bus.inc_r});
        end
        #3;
        resetn = 1'b0;
        #1;
        checks++;
        if ({bus.inc_l, bus.inc_m, bus.inc_r, bus.load_out} !== 4'b0000) begin
            failures++;
            $display("FAIL abort_pulses: got %b required 0000",
                     {bus.inc_l, bus.inc_m, bus.inc_r, bus.load_out});
        end
        checks++;
        if (bus.key_ready !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: ready/busy=%b%b required 10", bus.key_ready, bus.busy);
        end
        #2;
        resetn = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            checks++;
            if ({bus.inc_l, bus.inc_m, bus.inc_r, bus.step_done, bus.key_ready} !== 5'b00001) begin
                failures++;
                $display("FAIL abort_after c%0d: got %b required 00001", j,
                         {bus.inc_l, bus.inc_m, bus.inc_r, bus.step_done, bus.key_ready});
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_step_vectors();
        test_priority();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
